// File: rtl/track_dump_ctrl_pkg.sv
// Shared types and widths for the tracking-channel dump controller.
// ACC_WIDTH mirrors the global subchannel accumulator width.
package track_dump_ctrl_pkg;

  localparam int unsigned ACC_WIDTH = 16;

  typedef enum logic [1:0] {
    StWaitSync  = 2'd0,
    StIntegrate = 2'd1,
    StDrain     = 2'd2,
    StLatch     = 2'd3
  } dump_state_e;

endpackage

// File: rtl/track_dump_ctrl_if.sv
// Valid/ready link carrying a latched E/P/L snapshot to the tracking-loop processor.
interface track_dump_ctrl_if #(
  parameter int unsigned NUM_SUB   = 3,
  parameter int unsigned CNT_WIDTH = 16
) ();
  import track_dump_ctrl_pkg::*;

  logic [NUM_SUB*ACC_WIDTH-1:0] dump_data;
  logic [CNT_WIDTH-1:0]         dump_seq;
  logic                         dump_valid;
  logic                         dump_ready;

  modport master (
    output dump_data,
    output dump_seq,
    output dump_valid,
    input  dump_ready
  );

  modport slave (
    input  dump_data,
    input  dump_seq,
    input  dump_valid,
    output dump_ready
  );

endinterface

// File: rtl/dump_holding_reg.sv
// Skid-free output register: a new load overwrites any pending snapshot and flags overrun
// if that snapshot had not been accepted.
module dump_holding_reg
  import track_dump_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SUB   = 3,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         load,
  input  logic [NUM_SUB*ACC_WIDTH-1:0] load_data,
  output logic                         overrun,
  track_dump_ctrl_if.master            dump
);

  logic [NUM_SUB*ACC_WIDTH-1:0] data_q, data_d;
  logic [CNT_WIDTH-1:0]         seq_q, seq_d;
  logic                         valid_q, valid_d;
  logic                         overrun_q, overrun_d;

  always_comb begin
    data_d    = data_q;
    seq_d     = seq_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (load) begin
      data_d  = load_data;
      seq_d   = seq_q + 1'b1;
      valid_d = 1'b1;
      // A load in the same cycle as acceptance retires the old dump cleanly.
      if (valid_q && !dump.dump_ready) begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && dump.dump_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q    <= '0;
      seq_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      seq_q     <= seq_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign dump.dump_data  = data_q;
  assign dump.dump_seq   = seq_q;
  assign dump.dump_valid = valid_q;
  assign overrun         = overrun_q;

endmodule

// File: rtl/track_dump_ctrl.sv
// Ends coherent integration intervals on C/A epochs, snapshots E/P/L accumulators after the
// subchannel pipeline drains, clears the subchannels and presents the snapshot downstream.
module track_dump_ctrl
  import track_dump_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SUB     = 3,
  parameter int unsigned INT_EPOCHS  = 1,
  parameter int unsigned DRAIN_DELAY = 6,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic                         seek_en,
  input  logic                         ca_epoch,
  input  logic [NUM_SUB*ACC_WIDTH-1:0] accumulators,
  output logic                         acc_clear,
  output logic                         overrun,
  output logic                         aborted,
  track_dump_ctrl_if.master            dump
);

  localparam int unsigned EpochW = $clog2(INT_EPOCHS + 1);
  localparam int unsigned DrainW = $clog2(DRAIN_DELAY + 1);
  localparam logic [EpochW-1:0] EpochLast = EpochW'(INT_EPOCHS - 1);
  localparam logic [DrainW-1:0] DrainLast = DrainW'(DRAIN_DELAY - 1);

  dump_state_e       state_q, state_d;
  logic [EpochW-1:0] epoch_cnt_q, epoch_cnt_d;
  logic [DrainW-1:0] drain_cnt_q, drain_cnt_d;
  logic              acc_clear_q, acc_clear_d;
  logic              aborted_q, aborted_d;
  logic              load;
  logic              abort;

  assign abort = (seek_en || !enable) && (state_q != StWaitSync);

  always_comb begin
    state_d     = state_q;
    epoch_cnt_d = epoch_cnt_q;
    drain_cnt_d = drain_cnt_q;
    acc_clear_d = 1'b0;
    aborted_d   = 1'b0;
    load        = 1'b0;
    if (abort) begin
      // Abort outranks a pending latch; any already-presented dump stays valid.
      state_d     = StWaitSync;
      acc_clear_d = 1'b1;
      aborted_d   = 1'b1;
    end else begin
      unique case (state_q)
        StWaitSync: begin
          if (ca_epoch && enable && !seek_en) begin
            acc_clear_d = 1'b1;
            epoch_cnt_d = '0;
            state_d     = StIntegrate;
          end
        end
        StIntegrate: begin
          if (ca_epoch) begin
            if (epoch_cnt_q == EpochLast) begin
              drain_cnt_d = '0;
              state_d     = StDrain;
            end else begin
              epoch_cnt_d = epoch_cnt_q + 1'b1;
            end
          end
        end
        StDrain: begin
          if (drain_cnt_q == DrainLast) begin
            state_d = StLatch;
          end else begin
            drain_cnt_d = drain_cnt_q + 1'b1;
          end
        end
        StLatch: begin
          load        = 1'b1;
          acc_clear_d = 1'b1;
          epoch_cnt_d = '0;
          state_d     = StIntegrate;
        end
        default: state_d = StWaitSync;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StWaitSync;
      epoch_cnt_q <= '0;
      drain_cnt_q <= '0;
      acc_clear_q <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      epoch_cnt_q <= epoch_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      acc_clear_q <= acc_clear_d;
      aborted_q   <= aborted_d;
    end
  end

  assign acc_clear = acc_clear_q;
  assign aborted   = aborted_q;

  dump_holding_reg #(
    .NUM_SUB   (NUM_SUB),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_holding (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .load_data (accumulators),
    .overrun   (overrun),
    .dump      (dump)
  );

endmodule

// File: tb/tb_track_dump_ctrl.sv
// Directed bench for track_dump_ctrl: one-epoch and four-epoch instances share stimulus.
module tb_track_dump_ctrl;
  import track_dump_ctrl_pkg::*;

  localparam int unsigned DW = 3 * ACC_WIDTH;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          enable = 1'b0;
  logic          seek_en = 1'b0;
  logic          ca_epoch = 1'b0;
  logic [DW-1:0] accumulators;
  logic          acc_clear1, overrun1, aborted1;
  logic          acc_clear4, overrun4, aborted4;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int clr1_cnt = 0;
  int clr4_cnt = 0;
  bit clr_en = 1'b0;
  int e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] ramp(input int c);
    return {ACC_WIDTH'(c + 2), ACC_WIDTH'(c + 1), ACC_WIDTH'(c)};
  endfunction

  assign accumulators = ramp(cyc);

  track_dump_ctrl_if #(.NUM_SUB(3), .CNT_WIDTH(16)) dif1 ();
  track_dump_ctrl_if #(.NUM_SUB(3), .CNT_WIDTH(16)) dif4 ();

  track_dump_ctrl #(
    .NUM_SUB(3), .INT_EPOCHS(1), .DRAIN_DELAY(6), .CNT_WIDTH(16)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .seek_en(seek_en), .ca_epoch(ca_epoch),
    .accumulators(accumulators), .acc_clear(acc_clear1), .overrun(overrun1),
    .aborted(aborted1), .dump(dif1)
  );

  track_dump_ctrl #(
    .NUM_SUB(3), .INT_EPOCHS(4), .DRAIN_DELAY(6), .CNT_WIDTH(16)
  ) dut4 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .seek_en(seek_en), .ca_epoch(ca_epoch),
    .accumulators(accumulators), .acc_clear(acc_clear4), .overrun(overrun4),
    .aborted(aborted4), .dump(dif4)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (clr_en && acc_clear1) clr1_cnt++;
    if (clr_en && acc_clear4) clr4_cnt++;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic epoch(output int ec);
    ca_epoch = 1'b1;
    ec = cyc;
    step();
    ca_epoch = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dif1.dump_ready = 1'b0;
    dif4.dump_ready = 1'b0;

    reset_n = 1'b0;
    step();
    step();
    check_eq("rst_valid", dif1.dump_valid, 0);
    check_eq("rst_seq", dif1.dump_seq, 0);
    check_eq("rst_data", dif1.dump_data, 0);
    check_eq("rst_clear", acc_clear1, 0);
    check_eq("rst_overrun", overrun1, 0);
    check_eq("rst_aborted", aborted1, 0);
    reset_n = 1'b1;
    enable = 1'b1;
    repeat (3) step();

    // First epoch only synchronises and clears.
    epoch(e);
    check_eq("sync_clear", acc_clear1, 1);
    check_eq("sync_no_valid", dif1.dump_valid, 0);
    step();
    check_eq("sync_clear_pulse", acc_clear1, 0);

    // Test 1: dump appears 8 cycles after the epoch.
    wait_until(e + 50);
    epoch(e);
    wait_until(e + 7);
    check_eq("t1_valid_early", dif1.dump_valid, 0);
    step();
    check_eq("t1_valid", dif1.dump_valid, 1);
    check_eq("t1_clear", acc_clear1, 1);
    check_eq("t1_seq", dif1.dump_seq, 1);
    check_eq("t1_data", dif1.dump_data, ramp(e + 7));

    // Test 4: ready coincident with the latch cycle.
    wait_until(e + 50);
    epoch(e);
    wait_until(e + 7);
    dif1.dump_ready = 1'b1;
    step();
    dif1.dump_ready = 1'b0;
    check_eq("t4_valid", dif1.dump_valid, 1);
    check_eq("t4_seq", dif1.dump_seq, 2);
    check_eq("t4_overrun", overrun1, 0);
    check_eq("t4_data", dif1.dump_data, ramp(e + 7));

    // Test 3: unaccepted dump overwritten.
    wait_until(e + 25);
    check_eq("t3_hold_seq", dif1.dump_seq, 2);
    wait_until(e + 50);
    epoch(e);
    wait_until(e + 8);
    check_eq("t3_valid", dif1.dump_valid, 1);
    check_eq("t3_overrun", overrun1, 1);
    check_eq("t3_seq", dif1.dump_seq, 3);
    check_eq("t3_data", dif1.dump_data, ramp(e + 7));
    dif1.dump_ready = 1'b1;
    step();
    dif1.dump_ready = 1'b0;
    check_eq("t3_drop", dif1.dump_valid, 0);

    // Test 5: seek aborts mid-interval.
    wait_until(e + 25);
    seek_en = 1'b1;
    step();
    seek_en = 1'b0;
    check_eq("t5_aborted", aborted1, 1);
    check_eq("t5_clear", acc_clear1, 1);
    step();
    check_eq("t5_aborted_pulse", aborted1, 0);
    wait_until(e + 50);
    epoch(e);
    check_eq("t5_resync_clear", acc_clear1, 1);
    wait_until(e + 8);
    check_eq("t5_no_dump", dif1.dump_valid, 0);
    wait_until(e + 50);
    epoch(e);
    wait_until(e + 8);
    check_eq("t5_resume_valid", dif1.dump_valid, 1);
    check_eq("t5_resume_seq", dif1.dump_seq, 4);

    // Test 6: asynchronous reset during drain.
    wait_until(e + 50);
    epoch(e);
    wait_until(e + 3);
    reset_n = 1'b0;
    #2;
    check_eq("t6_valid", dif1.dump_valid, 0);
    check_eq("t6_seq", dif1.dump_seq, 0);
    check_eq("t6_overrun", overrun1, 0);
    check_eq("t6_clear", acc_clear1, 0);
    step();
    step();
    reset_n = 1'b1;
    wait_until(e + 10);
    check_eq("t6_no_dump", dif1.dump_valid, 0);

    // Test 2: four-epoch interval alongside the one-epoch instance.
    wait_until(e + 50);
    epoch(e);
    check_eq("t2_sync_clear4", acc_clear4, 1);
    step();
    clr_en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      wait_until(e + 50);
      epoch(e);
      wait_until(e + 8);
      if (k == 1) check_eq("t6_seq_restart", dif1.dump_seq, 1);
      if (k == 3) check_eq("t2_no_dump_3", dif4.dump_valid, 0);
    end
    check_eq("t2_valid", dif4.dump_valid, 1);
    check_eq("t2_seq", dif4.dump_seq, 1);
    check_eq("t2_data", dif4.dump_data, ramp(e + 7));
    check_eq("t2_clear4_once", clr4_cnt, 1);
    check_eq("t2_clear1_each", clr1_cnt, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
